// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and sizing helpers
package alu_pkg;

   typedef enum logic [1:0] {
      SUB_IDLE = 2'd0,
      SUB_RUN  = 2'd1,
      SUB_DONE = 2'd2
   } sub_state_e;

   // Bit counter width for a WIDTH-bit serial unit (never narrower than 1).
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - one-bit full subtractor from two half-subtractor stages
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic hs1_d;
   logic hs1_b;
   logic hs2_b;

   // First stage computes a - b, second stage removes the incoming borrow.
   assign hs1_d = a ^ b;
   assign hs1_b = ~a & b;

   assign d     = hs1_d ^ bin;
   assign hs2_b = ~hs1_d & bin;

   assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with borrow/zero/overflow flags
module serial_subtractor
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   sub_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bfl_q, bfl_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             cell_d;
   logic             cell_bout;

   full_subtractor_bit u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (bfl_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      bfl_d    = bfl_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;

      case (state_q)
         SUB_IDLE, SUB_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               res_d   = '0;
               cnt_d   = '0;
               bfl_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = SUB_RUN;
            end else begin
               state_d = SUB_IDLE;
            end
         end

         SUB_RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {cell_d, res_q[WIDTH-1:1]};
            bfl_d = cell_bout;
            if (cnt_q == LAST) begin
               // On the MSB edge a_q[0]/b_q[0] are the captured sign bits.
               state_d  = SUB_DONE;
               done_d   = 1'b1;
               diff_d   = res_d;
               borrow_d = cell_bout;
               zero_d   = (res_d == '0);
               ovf_d    = (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_d);
            end else begin
               cnt_d  = cnt_q + CW'(1);
               busy_d = 1'b1;
            end
         end

         default: state_d = SUB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SUB_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         bfl_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         bfl_q    <= bfl_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W       = 8;
   localparam int TIMEOUT = 50;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         zero;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Reference: {ovf, zero, borrow, diff} from plain integer arithmetic.
   function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      int ux, uy, sx, sy, sr;
      logic [W-1:0] dv;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 128) ? ux - 256 : ux;
      sy = (uy >= 128) ? uy - 256 : uy;
      sr = sx - sy;
      dv = W'((ux - uy + 256) % 256);
      return {(sr > 127 || sr < -128), (dv == 0), (ux < uy), dv};
   endfunction

   // Launch one operation from IDLE and wait for done; returns edges after accept and busy cycles.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit keep_start,
                        output int lat, output int busy_cnt, output bit timed_out);
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      busy_cnt = busy ? 1 : 0;
      lat = 0;
      while (!done && lat < TIMEOUT) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (busy) busy_cnt++;
         if (keep_start) begin
            a = W'($urandom);
            b = W'($urandom);
         end
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      start = 1'b0;
      a = '0;
      b = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, diff, borrow, zero, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {busy, done, diff, borrow, zero, ovf});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bc;
      bit to;
      do_op(8'h05, 8'h03, 1'b0, lat, bc, to);
      total++;
      if (to || lat != W) begin
         bad++;
         $display("FAIL basic_latency got=%0d timeout=%0d want=%0d", lat, to, W);
      end
      total++;
      if (bc != W) begin
         bad++;
         $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, W);
      end
      total++;
      if ({ovf, zero, borrow, diff} !== {1'b0, 1'b0, 1'b0, 8'h02}) begin
         bad++;
         $display("FAIL basic_result got=%h want=%h", {ovf, zero, borrow, diff}, {3'b000, 8'h02});
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy_in_done got=%b want=0", busy);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || diff !== 8'h02) begin
         bad++;
         $display("FAIL basic_done_pulse_hold got done=%b diff=%h want done=0 diff=02", done, diff);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] tab_a [5] = '{8'h03, 8'h00, 8'h80, 8'h5A, 8'h7F};
      logic [W-1:0] tab_b [5] = '{8'h05, 8'h01, 8'h01, 8'h5A, 8'hFF};
      int lat, bc;
      bit to;
      logic [W+2:0] exp;
      for (int i = 0; i < 5; i++) begin
         do_op(tab_a[i], tab_b[i], 1'b0, lat, bc, to);
         exp = ref_sub(tab_a[i], tab_b[i]);
         total++;
         if (to || {ovf, zero, borrow, diff} !== exp) begin
            bad++;
            $display("FAIL directed_%0d %h-%h got=%h want=%h timeout=%0d",
                     i, tab_a[i], tab_b[i], {ovf, zero, borrow, diff}, exp, to);
         end
      end
   endtask

   task automatic test_hold_start();
      int lat, bc;
      bit to;
      do_op(8'h37, 8'h12, 1'b1, lat, bc, to);
      total++;
      if (to || lat != W || diff !== 8'h25 || borrow !== 1'b0) begin
         bad++;
         $display("FAIL hold_start got diff=%h borrow=%b lat=%0d want diff=25 borrow=0 lat=%0d",
                  diff, borrow, lat, W);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      bit to;
      do_op(8'h44, 8'h04, 1'b0, lat, bc, to);
      a = 8'h10;
      b = 8'h01;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_reaccept got done=%b busy=%b want done=0 busy=1", done, busy);
      end
      lat = 0;
      while (!done && lat < TIMEOUT) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      total++;
      if (lat != W || diff !== 8'h0F || borrow !== 1'b0) begin
         bad++;
         $display("FAIL b2b_result got diff=%h lat=%0d want diff=0f lat=%0d", diff, lat, W);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      bit to;
      do_op(8'h80, 8'h01, 1'b0, lat, bc, to);
      @(negedge clk);
      a = 8'h22;
      b = 8'h11;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, diff, borrow, zero, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, diff, borrow, zero, ovf});
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h09, 8'h04, 1'b0, lat, bc, to);
      total++;
      if (to || lat != W || diff !== 8'h05 || {ovf, zero, borrow} !== 3'b000) begin
         bad++;
         $display("FAIL reset_mid_recover got diff=%h lat=%0d want diff=05 lat=%0d", diff, lat, W);
      end
   endtask

   task automatic test_random();
      int lat, bc;
      bit to;
      logic [W-1:0] ra, rb;
      logic [W+2:0] exp;
      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         do_op(ra, rb, 1'b0, lat, bc, to);
         exp = ref_sub(ra, rb);
         total++;
         if (to || lat != W || {ovf, zero, borrow, diff} !== exp) begin
            bad++;
            $display("FAIL random_%0d %h-%h got=%h lat=%0d want=%h lat=%0d",
                     i, ra, rb, {ovf, zero, borrow, diff}, lat, exp, W);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_directed();
      test_hold_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor for the arithmetic logic unit; computes DIFF = A - B LSB-first, one bit per clock.
- Datapath is a single borrow-chained subtract cell plus one borrow flip-flop. It replaces a WIDTH-wide ripple chain when area matters more than latency.
- Start/busy/done handshake to the ALU controller. Results include borrow, zero and signed-overflow flags.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when accept is possible (see Behaviour)
- a  input  WIDTH  minuend, captured on accept
- b  input  WIDTH  subtrahend, captured on accept
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result outputs valid and updated
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  unsigned borrow out (1 when a < b unsigned)
- zero  output  1  1 when diff == 0
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state = IDLE; busy = 0, done = 0, diff = 0, borrow = 0, zero = 0, ovf = 0. Internal shift registers, bit counter and borrow flip-flop are cleared.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and outputs return to reset values.
- States:
  - IDLE: start = 1 -> accept: capture a, b; clear borrow FF; clear count; go to RUN.
  - RUN: busy = 1. Each edge processes bit `count`: d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin). d shifts into the result register MSB-side, bout goes to the borrow FF, and count increments. The edge processing bit WIDTH-1 goes to DONE.
  - DONE: lasts exactly one cycle; done = 1, busy = 0. Next edge: start = 1 -> accept (same as IDLE) and go to RUN; else go to IDLE.
- Latency: the accept edge is E0. done is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after accept. Back-to-back throughput is one result per WIDTH+1 cycles.
- Output timing: diff, borrow, zero and ovf are registered. They update only on the edge entering DONE and hold until the next DONE or reset.
  - diff does not change during RUN; a partial result is held internally.
- Flags:
  - borrow = final borrow FF value.
  - zero = (diff == 0).
  - ovf = (a[W-1] ^ b[W-1]) & (a[W-1] ^ diff[W-1]), using the captured operands.
- start while in RUN is ignored: no queueing and no error.
- a and b may change freely after the accept edge.
- Wrap-around: the result is modulo 2^WIDTH. 0 - 1 gives all ones with borrow = 1.
- Counter width: $clog2(WIDTH). It stops at WIDTH-1 and never wraps during RUN.

Decomposition:
- Shared package alu_pkg:
  - state enum SUB_IDLE/SUB_RUN/SUB_DONE (2 bits);
  - localparam for the counter width function.
- One sub-module: full_subtractor_bit (combinational; inputs a, b, bin; outputs d, bout). It is built as two half-subtractor stages plus an OR, mirroring the half-adder structure used elsewhere in the ALU.
- The FSM, shift registers and flags stay in serial_subtractor.

Test Plan (WIDTH = 8):
- Basic: start with a = 0x05, b = 0x03 -> done 8 cycles after accept; diff = 0x02, borrow = 0, zero = 0, ovf = 0. busy is high for exactly 8 cycles.
- Negative / wrap: a = 0x03, b = 0x05 -> diff = 0xFE, borrow = 1, ovf = 0. Also a = 0x00, b = 0x01 -> diff = 0xFF, borrow = 1.
- Overflow and zero:
  - a = 0x80, b = 0x01 -> diff = 0x7F, ovf = 1, borrow = 0.
  - a = 0x5A, b = 0x5A -> diff = 0x00, zero = 1, borrow = 0.
- Handshake:
  - Hold start = 1 during RUN with changing a/b -> ignored; the result reflects the captured operands.
  - start in the DONE cycle (a = 0x10, b = 0x01) -> immediate re-accept; next done gives 0x0F. done is never high for 2 consecutive cycles.
- Reset mid-op: assert rst_n = 0 at cycle 4 of RUN (asynchronously, between edges) -> busy, done and all outputs drop to 0 at once. After release, a fresh 0x09 - 0x04 yields 0x05 with correct latency.
- Regression: 200 random a/b pairs, each checked against a reference a - b for diff, borrow, zero and ovf.
